// File: rtl/leopard_pkg.sv
// leopard_pkg: shared types and constants for the leopard_voice sample voice
package leopard_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam logic [2:0] REG_WPTR       = 3'd0;
    localparam logic [2:0] REG_LOOP_START = 3'd1;
    localparam logic [2:0] REG_LOOP_END   = 3'd2;
    localparam logic [2:0] REG_PITCH      = 3'd3;
    localparam logic [2:0] REG_OCTAVE     = 3'd4;
    localparam logic [2:0] REG_VOLUME     = 3'd5;
    localparam logic [2:0] REG_MODE       = 3'd6;
    localparam logic [2:0] OCTAVE_MAX     = 3'd4;
endpackage

// File: rtl/leopard_voice_if.sv
// leopard_voice_if: register and wavetable write bus
// reg_wen/reg_addr/reg_wdata: register write; wt_wen: wavetable write at WPTR
interface leopard_voice_if #(parameter int REG_W = 16);
    logic             reg_wen;
    logic [2:0]       reg_addr;
    logic [REG_W-1:0] reg_wdata;
    logic             wt_wen;
    modport master(output reg_wen, reg_addr, reg_wdata, wt_wen);
    modport slave(input reg_wen, reg_addr, reg_wdata, wt_wen);
endinterface

// File: rtl/leopard_wavetable_ram.sv
// leopard_wavetable_ram: simple dual-port wavetable, read returns old data on collision
// clk; we_i/waddr_i/wdata_i: write port; re_i/raddr_i/rdata_o: registered read port
module leopard_wavetable_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/leopard_voice.sv
// leopard_voice: looped/one-shot wavetable voice with fractional pitch, octave and volume
// aclk/areset: clock, sync reset; sample_tick: rate enable; sample_gate: play level
// bus: register/wavetable writes; sample_out/sample_valid: scaled sample and strobe
// playing: voice is in PLAY
module leopard_voice
    import leopard_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int FRAC_W = 8,
    parameter int VOL_W  = 8,
    parameter int REG_W  = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              sample_tick,
    input  logic                              sample_gate,
    leopard_voice_if.slave                    bus,
    output logic signed [DATA_W+VOL_W-1:0]    sample_out,
    output logic                              sample_valid,
    output logic                              playing
);
    localparam int PH_W = ADDR_W + FRAC_W;
    state_t              state_q;
    logic [ADDR_W-1:0]   wptr_q, loop_start_q, loop_end_q, loop_end_eff;
    logic [FRAC_W-1:0]   pitch_q;
    logic [2:0]          octave_q;
    logic [VOL_W-1:0]    volume_q;
    logic                mode_q, gate_q, v1_q, rise, rd_en;
    logic [PH_W-1:0]     phase_q;
    logic [PH_W:0]       inc, nxt;
    logic [DATA_W-1:0]   rdata;
    logic signed [DATA_W+VOL_W:0] prod;
    leopard_wavetable_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk    (aclk),
        .we_i   (bus.wt_wen),
        .waddr_i(wptr_q),
        .wdata_i(bus.reg_wdata[DATA_W-1:0]),
        .re_i   (rd_en),
        .raddr_i(phase_q[PH_W-1:FRAC_W]),
        .rdata_o(rdata)
    );
    always_comb begin
        loop_end_eff = (loop_end_q > loop_start_q) ? loop_end_q : loop_start_q;
        inc = {{(PH_W+1-FRAC_W){1'b0}}, pitch_q} << octave_q;
        // one extra bit so a step past the top of the table is not mistaken for a small index
        nxt = {1'b0, phase_q} + inc;
        rise = sample_gate & ~gate_q;
        rd_en = sample_tick & sample_gate & (state_q == PLAY);
        prod = $signed(rdata) * $signed({1'b0, volume_q});
    end
    assign playing = (state_q == PLAY);
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            loop_start_q <= '0;
            loop_end_q   <= '1;
            pitch_q      <= '0;
            octave_q     <= '0;
            volume_q     <= '0;
            mode_q       <= 1'b0;
            gate_q       <= 1'b0;
            v1_q         <= 1'b0;
            phase_q      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            gate_q <= sample_gate;
            // register write to WPTR overrides the wavetable post-increment
            if (bus.reg_wen && bus.reg_addr == REG_WPTR) wptr_q <= bus.reg_wdata[ADDR_W-1:0];
            else if (bus.wt_wen) wptr_q <= wptr_q + 1'b1;
            if (bus.reg_wen) begin
                case (bus.reg_addr)
                    REG_LOOP_START: loop_start_q <= bus.reg_wdata[ADDR_W-1:0];
                    REG_LOOP_END:   loop_end_q   <= bus.reg_wdata[ADDR_W-1:0];
                    REG_PITCH:      pitch_q      <= bus.reg_wdata[FRAC_W-1:0];
                    REG_OCTAVE:     octave_q     <= (bus.reg_wdata[2:0] > OCTAVE_MAX) ? OCTAVE_MAX : bus.reg_wdata[2:0];
                    REG_VOLUME:     volume_q     <= bus.reg_wdata[VOL_W-1:0];
                    REG_MODE:       mode_q       <= bus.reg_wdata[0];
                    default: ;
                endcase
            end
            if (!sample_gate) state_q <= IDLE;
            else if (rise) begin
                state_q <= PLAY;
                phase_q <= {loop_start_q, {FRAC_W{1'b0}}};
            end else if (rd_en) begin
                if (nxt[PH_W:FRAC_W] <= {1'b0, loop_end_eff}) phase_q <= nxt[PH_W-1:0];
                else if (mode_q) phase_q <= {loop_start_q, nxt[FRAC_W-1:0]};
                else state_q <= DONE;
            end
            // gate low squashes the in-flight sample; outside PLAY the output rests at zero
            v1_q         <= rd_en;
            sample_valid <= v1_q & sample_gate;
            sample_out   <= !sample_gate ? '0 :
                            v1_q ? prod[DATA_W+VOL_W-1:0] :
                            (state_q == PLAY) ? sample_out : '0;
        end
    end
endmodule

// File: tb/tb_leopard_voice.sv
// tb_leopard_voice: directed bench with a cycle model of the voice and literal spot checks
module tb_leopard_voice;
    import leopard_pkg::*;
    logic clk = 1'b0, rst = 1'b1, sample_tick = 1'b0, sample_gate = 1'b0;
    logic signed [15:0] sample_out;
    logic sample_valid, playing;
    int tests = 0, fails = 0;
    leopard_voice_if #(.REG_W(16)) bus();
    leopard_voice dut (
        .aclk(clk), .areset(rst), .sample_tick(sample_tick), .sample_gate(sample_gate),
        .bus(bus), .sample_out(sample_out), .sample_valid(sample_valid), .playing(playing)
    );
    always #5 clk = ~clk;

    logic signed [7:0] m_tab [4096];
    int m_wptr, m_ls, m_le, m_pitch, m_oct, m_vol, m_loop, m_state, phase, p1_val;
    bit gprev, p1, started = 0;
    int e_out, e_valid, e_play;

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // model: m_state 0 idle, 1 playing, 2 finished; phase in 1/256 sample units
    always @(posedge clk) begin
        int nxt, lend, wd;
        started = 1;
        wd = int'(bus.reg_wdata);
        if (rst) begin
            m_wptr = 0; m_ls = 0; m_le = 4095; m_pitch = 0; m_oct = 0; m_vol = 0; m_loop = 0;
            m_state = 0; phase = 0; gprev = 0; p1 = 0; e_out = 0; e_valid = 0; e_play = 0;
        end else begin
            if (!sample_gate) begin e_valid = 0; e_out = 0; end
            else if (p1) begin e_valid = 1; e_out = p1_val * m_vol; end
            else begin e_valid = 0; if (m_state != 1) e_out = 0; end
            p1 = sample_gate && sample_tick && m_state == 1;
            if (p1) p1_val = m_tab[phase / 256];
            if (!sample_gate) m_state = 0;
            else if (!gprev) begin m_state = 1; phase = m_ls * 256; end
            else if (p1) begin
                nxt = phase + m_pitch * (1 << m_oct);
                lend = (m_le > m_ls) ? m_le : m_ls;
                if (nxt / 256 <= lend) phase = nxt;
                else if (m_loop != 0) phase = m_ls * 256 + nxt % 256;
                else m_state = 2;
            end
            gprev = sample_gate;
            if (bus.wt_wen) begin
                m_tab[m_wptr] = bus.reg_wdata[7:0];
                m_wptr = (m_wptr + 1) % 4096;
            end
            if (bus.reg_wen) begin
                if (bus.reg_addr == REG_WPTR) m_wptr = wd % 4096;
                if (bus.reg_addr == REG_LOOP_START) m_ls = wd % 4096;
                if (bus.reg_addr == REG_LOOP_END) m_le = wd % 4096;
                if (bus.reg_addr == REG_PITCH) m_pitch = wd % 256;
                if (bus.reg_addr == REG_OCTAVE) m_oct = (wd % 8 > 4) ? 4 : wd % 8;
                if (bus.reg_addr == REG_VOLUME) m_vol = wd % 256;
                if (bus.reg_addr == REG_MODE) m_loop = wd % 2;
            end
            e_play = (m_state == 1) ? 1 : 0;
        end
    end

    always @(negedge clk) if (started) begin
        chk("model.out", int'(sample_out), e_out);
        chk("model.valid", int'(sample_valid), e_valid);
        chk("model.playing", int'(playing), e_play);
    end

    task automatic step(input bit tk);
        sample_tick = tk;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        bus.reg_wen = 1'b0;
        bus.wt_wen = 1'b0;
    endtask
    task automatic wreg(input logic [2:0] a, input logic [15:0] d);
        bus.reg_wen = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
        step(0);
    endtask
    task automatic wtab(input logic [15:0] d);
        bus.wt_wen = 1'b1; bus.reg_wdata = d;
        step(0);
    endtask
    task automatic lit(input string n, input int eo, input int ev);
        chk({n, ".out"}, int'(sample_out), eo);
        chk({n, ".valid"}, int'(sample_valid), ev);
    endtask
    task automatic regate();
        sample_gate = 1'b0; step(0);
        sample_gate = 1'b1; step(0);
    endtask

    initial begin
        int e2[6];
        int e4[4];
        e2 = '{32385, -32640, 255, 32385, -32640, 255};
        e4 = '{4080, 8160, 12240, 4080};
        bus.reg_wen = 1'b0; bus.wt_wen = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        step(0); step(0);
        lit("reset", 0, 0);
        chk("reset.playing", int'(playing), 0);
        rst = 1'b0;
        step(0);
        // table fill and single held sample
        wreg(REG_WPTR, 16'h0000);
        wtab(16'h007F); wtab(16'h0080); wtab(16'h0001);
        wreg(REG_VOLUME, 16'h00FF); wreg(REG_PITCH, 16'h0000); wreg(REG_OCTAVE, 16'h0001); wreg(REG_MODE, 16'h0000);
        sample_gate = 1'b1; step(0);
        chk("start.playing", int'(playing), 1);
        step(1); step(1);
        lit("first", 32385, 1);
        step(0);
        lit("repeat", 32385, 1);
        step(0);
        lit("hold", 32385, 0);
        // loop 0..2 at 1.0 sample per tick, back-to-back ticks
        sample_gate = 1'b0; step(0);
        wreg(REG_PITCH, 16'h0080); wreg(REG_LOOP_START, 16'h0000); wreg(REG_LOOP_END, 16'h0002); wreg(REG_MODE, 16'h0001);
        sample_gate = 1'b1; step(0);
        for (int i = 0; i < 8; i++) begin
            step(i < 6);
            if (i >= 1 && i <= 6) lit("loop", e2[i-1], 1);
            if (i == 7) chk("loop.idle_valid", int'(sample_valid), 0);
        end
        // one-shot ending after index 1
        sample_gate = 1'b0; step(0);
        wreg(REG_MODE, 16'h0000); wreg(REG_LOOP_END, 16'h0001);
        sample_gate = 1'b1; step(0);
        step(1); step(1);
        lit("oneshot0", 32385, 1);
        chk("oneshot.done_playing", int'(playing), 0);
        step(1);
        lit("oneshot1", -32640, 1);
        step(0);
        lit("done", 0, 0);
        chk("done.playing", int'(playing), 0);
        regate();
        step(1); step(0);
        lit("restart", 32385, 1);
        // loop start above loop end, octave clamp
        wreg(REG_WPTR, 16'h0005);
        wtab(16'h0010); wtab(16'h0020); wtab(16'h0030);
        wreg(REG_LOOP_START, 16'h0005); wreg(REG_LOOP_END, 16'h0003);
        wreg(REG_PITCH, 16'h0010); wreg(REG_OCTAVE, 16'h0007); wreg(REG_MODE, 16'h0001);
        regate();
        step(1); step(1);
        lit("single0", 4080, 1);
        step(0);
        lit("single1", 4080, 1);
        wreg(REG_LOOP_END, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            step(i < 4);
            if (i >= 1) lit("oct_clamp", e4[i-1], 1);
        end
        // read/write collision returns old data
        wreg(REG_LOOP_END, 16'h0003);
        regate();
        wreg(REG_WPTR, 16'h0005);
        bus.wt_wen = 1'b1; bus.reg_wdata = 16'h0040;
        step(1);
        step(1);
        lit("collide_old", 4080, 1);
        step(0);
        lit("collide_new", 16320, 1);
        // volume written in the tick cycle applies to that tick
        bus.reg_wen = 1'b1; bus.reg_addr = REG_VOLUME; bus.reg_wdata = 16'h0002;
        step(1);
        step(0);
        lit("vol_t1", 128, 1);
        // reset squashes an in-flight sample
        step(1);
        rst = 1'b1;
        step(0);
        lit("mid_reset", 0, 0);
        chk("mid_reset.playing", int'(playing), 0);
        sample_gate = 1'b0;
        rst = 1'b0;
        step(0);
        lit("post_reset", 0, 0);
        step(0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
